// File: rtl/mmio_bridge.sv
// CPU byte-bus bridge: RAM/IO decode, UART TX/RX byte FIFOs,
// free-running cycle counter with snapshot, program-stop pulse.
module mmio_bridge #(
  parameter int FIFO_LOG    = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_finish
);
  localparam int DEPTH = 1 << FIFO_LOG;
  localparam int HIGH  = DEPTH - FULL_MARGIN;
  localparam logic [FIFO_LOG:0] CNT_FULL = DEPTH[FIFO_LOG:0];
  localparam logic [FIFO_LOG:0] CNT_HIGH = HIGH[FIFO_LOG:0];

  typedef enum logic [2:0] {
    S_ZERO, S_RAM, S_RX, S_CNT0, S_CNT1, S_CNT2, S_CNT3
  } sel_t;

  sel_t                sel, sel_nxt;
  logic                io, hit_data, hit_cnt;
  logic                rd_en, wr_en, fin_hit;
  logic [7:0]          tx_mem [DEPTH];
  logic [7:0]          rx_mem [DEPTH];
  logic [FIFO_LOG-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [FIFO_LOG:0]   tx_count, rx_count;
  logic [FIFO_LOG:0]   tx_cnt_nxt, rx_cnt_nxt;
  logic                tx_push, tx_ok, tx_pop;
  logic                rx_ok, rx_pop;
  logic [7:0]          tx_byte, rx_q;
  logic [31:0]         cycle_cnt, snap;
  logic                tx_overflow, rx_overflow;
  logic                unused_bits;

  assign io       = (cpu_a[17:16] == 2'b11);
  assign hit_data = io && (cpu_a[15:0] == 16'h0000);
  assign hit_cnt  = io && (cpu_a[15:2] == 14'h0001);
  assign rd_en    = rdy_in && !cpu_wr;
  assign wr_en    = rdy_in && cpu_wr;
  assign fin_hit  = wr_en && hit_cnt
                 && (cpu_a[1:0] == 2'b00);

  assign ram_a    = cpu_a[16:0];
  assign ram_dout = cpu_dout;
  assign ram_wr   = cpu_wr && !io && rdy_in;

  // the stop write injects a 0x00 marker past the zero filter
  assign tx_push  = (wr_en && hit_data
                 && (cpu_dout != 8'h00)) || fin_hit;
  assign tx_byte  = hit_data ? cpu_dout : 8'h00;
  assign tx_ok    = tx_push && (tx_count != CNT_FULL);
  assign tx_valid = (tx_count != '0);
  assign tx_data  = tx_mem[tx_rp];
  assign tx_pop   = tx_valid && tx_ready;

  assign rx_ok    = rx_valid && (rx_count != CNT_FULL);
  assign rx_pop   = rd_en && hit_data && (rx_count != '0);

  assign unused_bits = ^{cpu_a[31:18], tx_overflow, rx_overflow};

  // next FIFO occupancies
  always_comb begin
    tx_cnt_nxt = tx_count;
    rx_cnt_nxt = rx_count;
    if (tx_ok && !tx_pop) tx_cnt_nxt = tx_count + 1'b1;
    else if (!tx_ok && tx_pop) tx_cnt_nxt = tx_count - 1'b1;
    if (rx_ok && !rx_pop) rx_cnt_nxt = rx_count + 1'b1;
    else if (!rx_ok && rx_pop) rx_cnt_nxt = rx_count - 1'b1;
  end

  // read-source select for the next cycle's cpu_din
  always_comb begin
    sel_nxt = sel;
    if (rd_en) begin
      unique case (1'b1)
        !io:      sel_nxt = S_RAM;
        hit_data: sel_nxt = S_RX;
        hit_cnt: begin
          case (cpu_a[1:0])
            2'd0:    sel_nxt = S_CNT0;
            2'd1:    sel_nxt = S_CNT1;
            2'd2:    sel_nxt = S_CNT2;
            default: sel_nxt = S_CNT3;
          endcase
        end
        default:  sel_nxt = S_ZERO;
      endcase
    end
  end

  // cpu read data mux
  always_comb begin
    cpu_din = 8'h00;
    case (sel)
      S_RAM:   cpu_din = ram_din;
      S_RX:    cpu_din = rx_q;
      S_CNT0:  cpu_din = snap[7:0];
      S_CNT1:  cpu_din = snap[15:8];
      S_CNT2:  cpu_din = snap[23:16];
      S_CNT3:  cpu_din = snap[31:24];
      default: cpu_din = 8'h00;
    endcase
  end

  // FIFO storage, contents need no reset
  always_ff @(posedge clk_in) begin
    if (tx_ok) tx_mem[tx_wp] <= tx_byte;
    if (rx_ok) rx_mem[rx_wp] <= rx_data;
  end

  // FIFO pointers/counts run regardless of rdy_in
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wp          <= '0;
      tx_rp          <= '0;
      tx_count       <= '0;
      rx_wp          <= '0;
      rx_rp          <= '0;
      rx_count       <= '0;
      tx_overflow    <= 1'b0;
      rx_overflow    <= 1'b0;
      io_buffer_full <= 1'b0;
      program_finish <= 1'b0;
    end else begin
      tx_count <= tx_cnt_nxt;
      rx_count <= rx_cnt_nxt;
      if (tx_ok)  tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      if (rx_ok)  rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      if (tx_push && !tx_ok) tx_overflow <= 1'b1;
      if (rx_valid && !rx_ok) rx_overflow <= 1'b1;
      io_buffer_full <= (tx_cnt_nxt >= CNT_HIGH);
      program_finish <= fin_hit;
    end
  end

  // cpu-side state, frozen while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel       <= S_ZERO;
      rx_q      <= 8'h00;
      cycle_cnt <= '0;
      snap      <= '0;
    end else if (rdy_in) begin
      sel       <= sel_nxt;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (rd_en && hit_data)
        rx_q <= (rx_count != '0) ? rx_mem[rx_rp] : 8'h00;
      if (rd_en && hit_cnt && (cpu_a[1:0] == 2'b00))
        snap <= cycle_cnt;
    end
  end
endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: directed sequence with random data,
// checked against queue/array models of RAM, FIFOs and counter.
module tb_mmio_bridge;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] cpu_a = '0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        program_finish;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  ram_mem [0:131071];
  logic [7:0]  ram_exp [int];
  logic [7:0]  exp_tx[$];
  logic [7:0]  got_tx[$];
  logic [7:0]  exp_rx[$];
  logic [31:0] m_cnt;

  mmio_bridge dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
    .cpu_din(cpu_din), .io_buffer_full(io_buffer_full),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout),
    .ram_din(ram_din), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .program_finish(program_finish)
  );

  always #5 clk_in = ~clk_in;

  // synchronous RAM with one-cycle read latency
  always @(posedge clk_in) begin
    if (ram_wr) ram_mem[ram_a] <= ram_dout;
    ram_din <= ram_mem[ram_a];
  end

  // bytes seen by the UART transmitter
  always @(posedge clk_in)
    if (rst_in && tx_valid && tx_ready) got_tx.push_back(tx_data);

  // number of ready cycles since reset
  always @(posedge clk_in or negedge rst_in)
    if (!rst_in) m_cnt <= '0;
    else if (rdy_in) m_cnt <= m_cnt + 32'd1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr,
                          input logic [7:0] data);
    logic is_io;
    cpu_a = addr;
    cpu_dout = data;
    cpu_wr = 1'b1;
    @(negedge clk_in);
    is_io = (addr[17:16] == 2'b11);
    chk("ram_wr", {31'd0, ram_wr}, {31'd0, !is_io && rdy_in});
    if (rdy_in && is_io) begin
      if ((addr[17:0] == 18'h30000 && data != 8'h00)
          || addr[17:0] == 18'h30004) begin
        if (exp_tx.size() - got_tx.size() < 16)
          exp_tx.push_back(addr[2] ? 8'h00 : data);
      end
    end
    if (rdy_in && !is_io) ram_exp[int'(addr[16:0])] = data;
    tick();
    cpu_wr = 1'b0;
    cpu_a = '0;
  endtask

  task automatic do_read(input logic [31:0] addr,
                         output logic [7:0] d,
                         output logic [31:0] c);
    cpu_a = addr;
    cpu_wr = 1'b0;
    @(negedge clk_in);
    c = m_cnt;
    tick();
    cpu_a = '0;
    @(negedge clk_in);
    d = cpu_din;
    tick();
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk_in);
    if (exp_rx.size() < 16) exp_rx.push_back(b);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic read_rx(input string tag);
    logic [7:0] d, e;
    logic [31:0] c;
    e = (exp_rx.size() != 0) ? exp_rx.pop_front() : 8'h00;
    do_read(32'h30000, d, c);
    chk(tag, {24'd0, d}, {24'd0, e});
  endtask

  task automatic cmp_tx(input string tag);
    logic [7:0] g;
    chk({tag, "_n"}, got_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) begin
      g = (i < got_tx.size()) ? got_tx[i] : 8'hxx;
      chk(tag, {24'd0, g}, {24'd0, exp_tx[i]});
    end
  endtask

  initial begin
    logic [7:0]  d, b0, b1, b2, b3;
    logic [31:0] c, c0, a;
    int          adr;

    // reset state
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_din", {24'd0, cpu_din}, 32'h0);
    chk("rst_txv", {31'd0, tx_valid}, 32'h0);
    chk("rst_full", {31'd0, io_buffer_full}, 32'h0);
    chk("rst_fin", {31'd0, program_finish}, 32'h0);
    tick();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    tick();

    // RAM read latency and random RAM traffic
    do_write(32'h10, 8'hA5);
    do_read(32'h10, d, c);
    chk("ram_a5", {24'd0, d}, 32'hA5);
    for (int i = 0; i < 8; i++)
      do_write({15'd0, 17'($urandom)}, 8'($urandom));
    rdy_in = 1'b0;
    do_write(32'h10, 8'h3C);
    rdy_in = 1'b1;
    foreach (ram_exp[k]) begin
      do_read(k, d, c);
      chk("ram_rd", {24'd0, d}, {24'd0, ram_exp[k]});
    end

    // TX path with zero filter
    tx_ready = 1'b1;
    do_write(32'h30000, 8'h48);
    do_write(32'h30000, 8'h00);
    do_write(32'h30000, 8'h69);
    for (int i = 0; i < 6; i++)
      do_write(32'h30000,
               ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom));
    repeat (20) tick();
    cmp_tx("tx_seq");
    if (got_tx.size() >= 2) begin
      chk("tx_h", {24'd0, got_tx[0]}, 32'h48);
      chk("tx_i", {24'd0, got_tx[1]}, 32'h69);
    end else begin
      chk("tx_short", got_tx.size(), 32'd2);
    end
    exp_tx.delete();
    got_tx.delete();

    // unmapped io accesses
    do_write(32'h30008, 8'h55);
    repeat (4) tick();
    chk("io_nop", got_tx.size(), 32'd0);
    do_read(32'h30010, d, c);
    chk("io_zero", {24'd0, d}, 32'h0);

    // TX fill, near-full flag, overflow, then drain
    tx_ready = 1'b0;
    for (int i = 0; i < 13; i++)
      do_write(32'h30000, 8'($urandom_range(1, 255)));
    repeat (2) tick();
    chk("full13", {31'd0, io_buffer_full}, 32'h0);
    do_write(32'h30000, 8'($urandom_range(1, 255)));
    tick();
    chk("full14", {31'd0, io_buffer_full}, 32'h1);
    do_write(32'h30000, 8'($urandom_range(1, 255)));
    do_write(32'h30000, 8'($urandom_range(1, 255)));
    chk("ovf16", {31'd0, dut.tx_overflow}, 32'h0);
    do_write(32'h30000, 8'($urandom_range(1, 255)));
    chk("ovf17", {31'd0, dut.tx_overflow}, 32'h1);
    tx_ready = 1'b1;
    repeat (25) tick();
    cmp_tx("tx_fill");
    chk("full_drn", {31'd0, io_buffer_full}, 32'h0);
    exp_tx.delete();
    got_tx.delete();

    // cycle counter snapshot
    for (int i = 0; i < 1000; i++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      tick();
    end
    rdy_in = 1'b1;
    do_read(32'h30004, b0, c0);
    repeat ($urandom_range(1, 20)) tick();
    do_read(32'h30005, b1, c);
    do_read(32'h30006, b2, c);
    do_read(32'h30007, b3, c);
    chk("cnt_b0", {24'd0, b0}, {24'd0, c0[7:0]});
    chk("cnt_word", {b3, b2, b1, b0}, c0);
    repeat ($urandom_range(1, 300)) tick();
    do_read(32'h30004, b0, c0);
    do_read(32'h30005, b1, c);
    chk("cnt2_b0", {24'd0, b0}, {24'd0, c0[7:0]});
    chk("cnt2_b1", {24'd0, b1}, {24'd0, c0[15:8]});

    // RX FIFO, pushes continue while rdy_in is low
    rdy_in = 1'b0;
    push_rx(8'h31);
    push_rx(8'h32);
    rdy_in = 1'b1;
    read_rx("rx_31");
    read_rx("rx_32");
    read_rx("rx_empty");
    chk("rx_cnt0", {27'd0, dut.rx_count}, 32'h0);
    chk("rx_ovf0", {31'd0, dut.rx_overflow}, 32'h0);
    for (int i = 0; i < 17; i++) push_rx(8'($urandom));
    chk("rx_ovf1", {31'd0, dut.rx_overflow}, 32'h1);
    for (int i = 0; i < 17; i++) read_rx("rx_rand");

    // program stop pulse and its 0x00 marker
    tx_ready = 1'b1;
    chk("fin_pre", {31'd0, program_finish}, 32'h0);
    do_write(32'h30004, 8'($urandom));
    chk("fin_hi", {31'd0, program_finish}, 32'h1);
    tick();
    chk("fin_lo", {31'd0, program_finish}, 32'h0);
    repeat (5) tick();
    cmp_tx("tx_fin");
    exp_tx.delete();
    got_tx.delete();

    // reset in the middle of a drain
    tx_ready = 1'b0;
    for (int i = 0; i < 14; i++)
      do_write(32'h30000, 8'($urandom_range(1, 255)));
    tick();
    chk("pre_txv", {31'd0, tx_valid}, 32'h1);
    chk("pre_full", {31'd0, io_buffer_full}, 32'h1);
    tx_ready = 1'b1;
    tick();
    #2;
    rst_in = 1'b0;
    #1;
    chk("mid_txv", {31'd0, tx_valid}, 32'h0);
    chk("mid_full", {31'd0, io_buffer_full}, 32'h0);
    chk("mid_din", {24'd0, cpu_din}, 32'h0);
    tick();
    rst_in = 1'b1;
    exp_tx.delete();
    got_tx.delete();
    repeat (10) tick();
    chk("post_tx", got_tx.size(), 32'd0);
    chk("post_txv", {31'd0, tx_valid}, 32'h0);

    a = 32'h0;
    adr = 0;
    if (a != 32'h0 || adr != 0) $display("note: unused locals");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
